// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core: forwarding selects,
// load-use, D-cache miss, multi-cycle execute and I-cache refill/redirect control.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MC_LATENCY = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  instr_hit_f_i,
    input  logic                  ic_repl_permit_i,
    input  logic [REG_ADDR_W-1:0] rs1_d_i,
    input  logic [REG_ADDR_W-1:0] rs2_d_i,
    input  logic [REG_ADDR_W-1:0] rs1_e_i,
    input  logic [REG_ADDR_W-1:0] rs2_e_i,
    input  logic [REG_ADDR_W-1:0] rd_e_i,
    input  logic                  load_e_i,
    input  logic                  mc_start_e_i,
    input  logic                  redirect_e_i,
    input  logic [REG_ADDR_W-1:0] rd_m_i,
    input  logic                  reg_write_m_i,
    input  logic                  mem_access_m_i,
    input  logic                  data_hit_m_i,
    input  logic [REG_ADDR_W-1:0] rd_w_i,
    input  logic                  reg_write_w_i,
    output logic                  stall_f_o,
    output logic                  stall_d_o,
    output logic                  stall_e_o,
    output logic                  stall_m_o,
    output logic                  stall_w_o,
    output logic                  flush_d_o,
    output logic                  flush_e_o,
    output logic                  flush_m_o,
    output logic [1:0]            forward_a_e_o,
    output logic [1:0]            forward_b_e_o,
    output logic                  redirect_pending_o,
    output logic                  mc_busy_o
);

    localparam int              CNT_W      = 8;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MC_LATENCY - 1);
    localparam bit              MC_ENABLED = (MC_LATENCY > 1);

    typedef enum logic [1:0] {
        FE_RUN      = 2'd0,
        FE_MISS     = 2'd1,
        FE_MISS_RDR = 2'd2
    } fe_state_t;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    fe_state_t        r_fe_state, w_fe_next;
    mc_state_t        r_mc_state, w_mc_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_pending, w_pending_next;

    logic       w_dmiss, w_load_use, w_mc_start, w_mc_hold, w_mc_stall;
    logic [4:0] w_stall;   // {F, D, E, M, W}
    logic [2:0] w_flush;   // {D, E, M}
    logic       w_pend_set;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  wr_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  wr_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs == {REG_ADDR_W{1'b0}}) begin
            sel = 2'b00;
        end else if (wr_m && (rs == rd_m)) begin
            sel = 2'b10;
        end else if (wr_w && (rs == rd_w)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign forward_a_e_o = fwd_sel(rs1_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
    assign forward_b_e_o = fwd_sel(rs2_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);

    assign w_dmiss    = mem_access_m_i && !data_hit_m_i;
    assign w_load_use = load_e_i && (rd_e_i != {REG_ADDR_W{1'b0}}) &&
                        ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
    assign w_mc_start = (r_mc_state == MC_IDLE) && mc_start_e_i && MC_ENABLED;
    // Counter value 1 is the op's final E cycle: no stall, the op advances.
    assign w_mc_hold  = (r_mc_state == MC_BUSY) && (r_cnt > 8'd1);
    assign w_mc_stall = w_mc_start || w_mc_hold;

    // Prioritised stall/flush outputs and front-end next state.
    always_comb begin
        w_stall        = 5'b00000;
        w_flush        = 3'b000;
        w_pend_set     = 1'b0;
        w_pending_next = r_pending;
        w_fe_next      = r_fe_state;
        if (!reset_n_i) begin
            w_stall = 5'b00000;
        end else if (w_dmiss) begin
            w_stall = 5'b11111;
        end else if (w_mc_stall) begin
            w_stall = 5'b11100;
            w_flush = 3'b001;
        end else begin
            case (r_fe_state)
                FE_RUN: begin
                    if (redirect_e_i) begin
                        w_flush = 3'b110;
                    end else if (!instr_hit_f_i) begin
                        w_stall   = 5'b11111;
                        w_fe_next = FE_MISS;
                    end else if (w_load_use) begin
                        w_stall = 5'b11000;
                        w_flush = 3'b010;
                    end else begin
                        w_stall = 5'b00000;
                    end
                end
                FE_MISS: begin
                    if (redirect_e_i && !ic_repl_permit_i) begin
                        w_stall        = 5'b11111;
                        w_flush        = 3'b100;
                        w_pend_set     = 1'b1;
                        w_pending_next = 1'b1;
                        w_fe_next      = FE_MISS_RDR;
                    end else if (redirect_e_i) begin
                        w_flush   = 3'b110;
                        w_fe_next = FE_RUN;
                    end else if (!instr_hit_f_i) begin
                        w_stall = 5'b11111;
                    end else begin
                        w_fe_next = FE_RUN;
                        if (w_load_use) begin
                            w_stall = 5'b11000;
                            w_flush = 3'b010;
                        end else begin
                            w_stall = 5'b00000;
                        end
                    end
                end
                FE_MISS_RDR: begin
                    w_stall = {!ic_repl_permit_i, 4'b1111};
                    w_flush = 3'b100;
                    if (ic_repl_permit_i) begin
                        w_flush        = 3'b110;
                        w_pending_next = 1'b0;
                        w_fe_next      = FE_RUN;
                    end else begin
                        w_fe_next = FE_MISS_RDR;
                    end
                end
                default: begin
                    w_fe_next      = FE_RUN;
                    w_pending_next = 1'b0;
                end
            endcase
        end
    end

    // Multi-cycle counter: frozen by a D-miss, leaves BUSY only once E actually advances.
    always_comb begin
        w_mc_next  = r_mc_state;
        w_cnt_next = r_cnt;
        if (w_dmiss) begin
            w_mc_next = r_mc_state;
        end else if (w_mc_start) begin
            w_mc_next  = MC_BUSY;
            w_cnt_next = CNT_LOAD;
        end else if (r_mc_state == MC_BUSY) begin
            if (r_cnt > 8'd1) begin
                w_cnt_next = r_cnt - 8'd1;
            end else if (!w_stall[2]) begin
                w_mc_next  = MC_IDLE;
                w_cnt_next = 8'd0;
            end else begin
                w_cnt_next = r_cnt;
            end
        end else begin
            w_mc_next = MC_IDLE;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_fe_state <= FE_RUN;
            r_mc_state <= MC_IDLE;
            r_cnt      <= 8'd0;
            r_pending  <= 1'b0;
        end else begin
            r_fe_state <= w_fe_next;
            r_mc_state <= w_mc_next;
            r_cnt      <= w_cnt_next;
            r_pending  <= w_pending_next;
        end
    end

    assign {stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o} = w_stall;
    assign {flush_d_o, flush_e_o, flush_m_o}                       = w_flush;
    assign redirect_pending_o = reset_n_i && (r_pending || w_pend_set);
    assign mc_busy_o          = reset_n_i && (w_mc_hold || (w_mc_start && !w_dmiss));

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Next-generation hazard and pipeline-control unit for the 5-stage RISC-V core, replacing the purely combinational hazard unit. It adds registered control for redirects that arrive during an instruction-cache refill, a counter-driven stall for a parametrised multi-cycle execute unit (mul/div), and data-cache miss stalls. It also provides parametrised register-address forwarding. It sits beside the datapath and drives every stage-register stall/flush and the execute-stage forwarding muxes.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width.
- MC_LATENCY, 32, total execute-stage cycles of a multi-cycle op; legal range 1–255. A value of 1 means no stall.

Ports:
- clk_i  in  1  core clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- instr_hit_f_i  in  1  I-cache hit for the current fetch.
- ic_repl_permit_i  in  1  I-cache refill complete; the fetch may be retried or redirected.
- rs1_d_i, rs2_d_i  in  REG_ADDR_W  decode source registers.
- rs1_e_i, rs2_e_i, rd_e_i  in  REG_ADDR_W  execute sources and destination.
- load_e_i  in  1  the instruction in E is a load.
- mc_start_e_i  in  1  a multi-cycle op is valid in E.
- redirect_e_i  in  1  E has resolved a misprediction and needs a PC redirect.
- rd_m_i  in  REG_ADDR_W; reg_write_m_i  in  1.
- mem_access_m_i  in  1; data_hit_m_i  in  1  D-cache access and hit in M.
- rd_w_i  in  REG_ADDR_W; reg_write_w_i  in  1.
- stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o  out  1 each.
- flush_d_o, flush_e_o, flush_m_o  out  1 each.
- forward_a_e_o, forward_b_e_o  out  2 each: 00 = none, 01 = from W, 10 = from M.
- redirect_pending_o  out  1  selects the latched redirect target as the PC source.
- mc_busy_o  out  1  a multi-cycle op is in progress.

## Operation
- **Forwarding (combinational).** For each of rs1_e and rs2_e:
  - Source register 0 gives 00.
  - Otherwise, a match with rd_m and reg_write_m gives 10.
  - Otherwise, a match with rd_w and reg_write_w gives 01.
  - Otherwise 00.
- **Load-use hazard.** Triggered when load_e_i is set and rd_e_i is nonzero and equals rs1_d_i or rs2_d_i. Response: stall_f = stall_d = 1, flush_e = 1.
- **D-cache miss.** Triggered when mem_access_m_i is set and data_hit_m_i is 0. Response: all five stalls = 1; all flushes = 0. This has the highest priority and freezes the FSM and the counter.
- **Multi-cycle op.** In MC_IDLE with mc_start_e_i set and MC_LATENCY > 1:
  - Load cnt = MC_LATENCY−1 and go to MC_BUSY.
  - In MC_BUSY: stall_f/d/e = 1, flush_m = 1, mc_busy_o = 1, and cnt decrements.
  - When cnt reaches 1 the next state is MC_IDLE and E advances.
  - The first cycle of mc_start_e_i also stalls; the total stall is MC_LATENCY−1 cycles.
- **Front-end FSM (FE_RUN, FE_MISS, FE_MISS_RDR):**
  - FE_RUN, instr_hit_f = 0 with no redirect: all five stalls = 1; go to FE_MISS.
  - FE_RUN, redirect_e_i = 1 (hit or miss): flush_d = flush_e = 1, stall_f = 0, stay in FE_RUN. A miss is abandoned because the PC changes.
  - FE_MISS, no redirect: all stalls = 1 until instr_hit_f = 1, then go to FE_RUN.
  - FE_MISS, redirect_e_i = 1 and ic_repl_permit_i = 0:
    - Set the pending flag; all stalls = 1, flush_d = 1, flush_e = 0.
    - Go to FE_MISS_RDR.
  - FE_MISS, redirect_e_i = 1 and ic_repl_permit_i = 1: treat as the FE_RUN redirect case and go to FE_RUN.
  - FE_MISS_RDR: stall_d/e/m/w = 1, flush_d = 1, redirect_pending_o = 1.
    - stall_f = ~ic_repl_permit_i.
    - When ic_repl_permit_i = 1: flush_e = 1, clear pending, go to FE_RUN.
- **Priority, highest first:** D-cache miss, MC_BUSY, front-end FSM, load-use. A lower-priority hazard is still evaluated next cycle.
- A flush and a stall on the same stage register resolve as flush.

## Timing
- Reset values:
  - FE_RUN, MC_IDLE, cnt = 0, pending = 0.
  - All stall and flush outputs = 0 (the forwarding terms are still combinational).
  - redirect_pending_o = 0, mc_busy_o = 0.
- All outputs are a combinational function of the inputs and registered state, settling in the same cycle with zero latency. State updates on the rising edge of clk_i.
- Asynchronous reset asserted mid-operation (during MC_BUSY or FE_MISS_RDR) immediately drops every output to its reset value; the pending redirect is discarded.
- mc_start_e_i is ignored while in MC_BUSY.
- redirect_e_i simultaneous with MC_BUSY is deferred, because E is stalled and redirect stays asserted.

## Test plan
- Forwarding sweep, for each of rs1_e and rs2_e over 0–31:
  - rd_m = rd_w = 5, both writes enabled: rs = 5 gives 10; rs = 0 gives 00.
  - reg_write_m = 0: rs = 5 gives 01.
- Load-use: load_e = 1, rd_e = 3, rs2_d = 3 gives stall_f = stall_d = flush_e = 1. With rd_e = 0, no stall.
- MC_LATENCY = 4, mc_start_e pulse: stall_f/d/e and flush_m high for exactly 3 cycles, then all low; mc_busy_o matches.
- I-miss then redirect:
  - Cycle 1: redirect with permit = 0 gives all stalls = 1, flush_d = 1, flush_e = 0, pending = 1.
  - Cycle 3: permit = 1 gives stall_f = 0, flush_d = flush_e = 1.
  - Next cycle: FE_RUN with all outputs 0.
- D-miss during MC_BUSY (MC_LATENCY = 4): all stalls = 1 and cnt is frozen; after the hit, the remaining busy cycles complete.
- Reset pulse in FE_MISS_RDR: outputs clear asynchronously; after release, redirect_pending_o = 0.
